// File: rtl/led_blink_bank.sv
// led_blink_bank: bank of NCH independent LED blink generators in the sys_clk domain.
// Each channel has a programmable half-period and a mode: off, square-wave toggle,
// one-cycle pulse every half+1 cycles, or registered pass-through of led_in.
// Channels are reconfigured by a one-cycle write strobe (cfg_we / cfg_ch).
// Optional build macro LED_BLINK_SYNC_EN: when defined, led_in is passed through a
// 2-flop synchronizer before PASS mode uses it (PASS latency 3 cycles instead of 1).
module led_blink_bank #(
  parameter int               NCH          = 4,
  parameter int               CNT_W        = 32,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(50000000),
  parameter logic [1:0]       DEFAULT_MODE = 2'd1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    cfg_we,
  input  logic [$clog2(NCH)-1:0]  cfg_ch,
  input  logic [CNT_W-1:0]        cfg_half,
  input  logic [1:0]              cfg_mode,
  input  logic [NCH-1:0]          led_in,
  output logic [NCH-1:0]          led_out,
  output logic [NCH-1:0]          wrap_pulse
);

  localparam int CH_W = $clog2(NCH);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_PULSE  = 2'd2,
    MODE_PASS   = 2'd3
  } mode_e;

  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [CNT_W-1:0] cnt_d  [NCH];
  logic [CNT_W-1:0] half_q [NCH];
  logic [CNT_W-1:0] half_d [NCH];
  mode_e            mode_q [NCH];
  mode_e            mode_d [NCH];
  logic [NCH-1:0]   led_q, led_d;
  logic [NCH-1:0]   wrap_q, wrap_d;
  logic [NCH-1:0]   pass_src;

`ifdef LED_BLINK_SYNC_EN
  logic [NCH-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer bringing led_in into the sys_clk domain.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= led_in;
      sync2_q <= sync1_q;
    end
  end

  assign pass_src = sync2_q;
`else
  // led_in is assumed already synchronous to sys_clk.
  assign pass_src = led_in;
`endif

  // Per-channel next state: mode-selected counter/LED update, then any config write overrides it.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      // NOTE: every output of this block gets a default before the case so no path leaves it unassigned (which would infer a latch).
      half_d[c] = half_q[c];
      mode_d[c] = mode_q[c];
      cnt_d[c]  = '0;
      led_d[c]  = 1'b0;
      wrap_d[c] = 1'b0;

      case (mode_q[c])
        MODE_TOGGLE: begin
          if (cnt_q[c] == half_q[c]) begin
            wrap_d[c] = 1'b1;
            led_d[c]  = ~led_q[c];
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
            led_d[c] = led_q[c];
          end
        end
        MODE_PULSE: begin
          if (cnt_q[c] == half_q[c]) begin
            wrap_d[c] = 1'b1;
            led_d[c]  = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
        end
        MODE_PASS: begin
          led_d[c] = pass_src[c];
        end
        default: begin
          // MODE_OFF: counter parked at 0, LED and strobe low.
        end
      endcase

      // A write restarts the channel's phase and wins over a same-cycle wrap.
      // Indices >= NCH never match any c, so such writes are dropped.
      if (cfg_we && (cfg_ch == CH_W'(c))) begin
        half_d[c] = cfg_half;
        mode_d[c] = mode_e'(cfg_mode);
        cnt_d[c]  = '0;
        led_d[c]  = 1'b0;
        wrap_d[c] = 1'b0;
      end
    end
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      // NOTE: these per-channel arrays are individual flops, not RAM, so every entry is reset explicitly.
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c]  <= '0;
        half_q[c] <= DEFAULT_HALF;
        mode_q[c] <= mode_e'(DEFAULT_MODE);
      end
      led_q  <= '0;
      wrap_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from the same pre-edge values.
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c]  <= cnt_d[c];
        half_q[c] <= half_d[c];
        mode_q[c] <= mode_d[c];
      end
      led_q  <= led_d;
      wrap_q <= wrap_d;
    end
  end

  assign led_out    = led_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_led_blink_bank.sv
// Self-checking bench for led_blink_bank: a 4-channel instance driven from a
// hand-computed cycle table plus hand-written PASS/OFF/reset sequences, and a
// 3-channel 4-bit-counter instance for the out-of-range write and max half-period.
module tb_led_blink_bank;

`ifdef LED_BLINK_SYNC_EN
  localparam int PASS_LAT = 3;
`else
  localparam int PASS_LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance, 8-bit counters, half = 3 at reset.
  logic       rst, we;
  logic [1:0] ch;
  logic [7:0] half;
  logic [1:0] mode;
  logic [3:0] led_in, led_out, wrap;

  led_blink_bank #(.NCH(4), .CNT_W(8), .DEFAULT_HALF(8'd3), .DEFAULT_MODE(2'd1)) dut4 (
    .sys_clk(clk), .sys_rst(rst), .cfg_we(we), .cfg_ch(ch), .cfg_half(half),
    .cfg_mode(mode), .led_in(led_in), .led_out(led_out), .wrap_pulse(wrap)
  );

  // 3-channel instance, 4-bit counters, half = 3 at reset.
  logic       rst_b, we_b;
  logic [1:0] ch_b;
  logic [3:0] half_b;
  logic [1:0] mode_b;
  logic [2:0] led_in_b, led_out_b, wrap_b;

  led_blink_bank #(.NCH(3), .CNT_W(4), .DEFAULT_HALF(4'd3), .DEFAULT_MODE(2'd1)) dut3 (
    .sys_clk(clk), .sys_rst(rst_b), .cfg_we(we_b), .cfg_ch(ch_b), .cfg_half(half_b),
    .cfg_mode(mode_b), .led_in(led_in_b), .led_out(led_out_b), .wrap_pulse(wrap_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic       we;
    logic [1:0] ch;
    logic [7:0] half;
    logic [1:0] mode;
    logic [3:0] exp_led;
    logic [3:0] exp_wrap;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs [NVEC];

  logic [2:0] exp3_led  [8];
  logic [2:0] exp3_wrap [8];

  initial begin
    int lat;
    bit seen;
    bit bad;

    rst = 1'b1; we = 1'b0; ch = '0; half = '0; mode = '0; led_in = '0;
    rst_b = 1'b1; we_b = 1'b0; ch_b = '0; half_b = '0; mode_b = '0; led_in_b = '0;

    // Each row: inputs applied before edge k, outputs expected just after edge k.
    //            rst   we    ch    half  mode   led    wrap
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 8'd0, 2'd0, 4'h0, 4'h0};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 8'd0, 2'd0, 4'h0, 4'h0};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'h0, 4'h0};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'h0, 4'h0};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'h0, 4'h0};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'hF, 4'hF};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'hF, 4'h0};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'hF, 4'h0};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'hF, 4'h0};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'h0, 4'hF};
    // ch1 -> toggle, half 0
    vecs[10] = '{1'b0, 1'b1, 2'd1, 8'd0, 2'd1, 4'h0, 4'h0};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'h2, 4'h2};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'h0, 4'h2};
    vecs[13] = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'hF, 4'hF};
    vecs[14] = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'hD, 4'h2};
    // ch2 -> pulse, half 5
    vecs[15] = '{1'b0, 1'b1, 2'd2, 8'd5, 2'd2, 4'hB, 4'h2};
    vecs[16] = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'h9, 4'h2};
    vecs[17] = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'h2, 4'hB};
    vecs[18] = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'h0, 4'h2};
    vecs[19] = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'h2, 4'h2};
    vecs[20] = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'h0, 4'h2};
    vecs[21] = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'hF, 4'hF};
    vecs[22] = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'h9, 4'h2};
    vecs[23] = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'hB, 4'h2};
    vecs[24] = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'h9, 4'h2};
    vecs[25] = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'h2, 4'hB};
    vecs[26] = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'h0, 4'h2};
    vecs[27] = '{1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 4'h6, 4'h6};

    exp3_led  = '{3'h0, 3'h0, 3'h0, 3'h7, 3'h7, 3'h7, 3'h7, 3'h0};
    exp3_wrap = '{3'h0, 3'h0, 3'h0, 3'h7, 3'h0, 3'h0, 3'h0, 3'h7};

    // ---- Table: reset, toggle, half=0 toggle, pulse mode ----
    for (int i = 0; i < NVEC; i++) begin
      rst  = vecs[i].rst;
      we   = vecs[i].we;
      ch   = vecs[i].ch;
      half = vecs[i].half;
      mode = vecs[i].mode;
      tick();
      check($sformatf("vec%0d_led", i), 32'(led_out), 32'(vecs[i].exp_led));
      check($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
    end
    we = 1'b0;

    // ---- PASS mode latency on ch3 ----
    we = 1'b1; ch = 2'd3; half = 8'd0; mode = 2'd3; led_in = 4'h0;
    tick();
    we = 1'b0;
    check("pass_write_led3", 32'(led_out[3]), 32'd0);
    led_in[3] = 1'b1;
    lat = 0;
    seen = 1'b0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      tick();
      if (led_out[3]) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check("pass_latency", 32'(lat), 32'(PASS_LAT));
    check("pass_wrap3", 32'(wrap[3]), 32'd0);

    // ---- OFF mode written while ch0 LED is high ----
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (led_out[0]) seen = 1'b1;
    end
    check("off_wait_led0_high", 32'(seen), 32'd1);
    we = 1'b1; ch = 2'd0; half = 8'd3; mode = 2'd0;
    tick();
    we = 1'b0;
    check("off_led0", 32'(led_out[0]), 32'd0);
    check("off_wrap0", 32'(wrap[0]), 32'd0);
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (led_out[0] || wrap[0]) bad = 1'b1;
    end
    check("off_hold", 32'(bad), 32'd0);

    // ---- Reset wins over a same-cycle write ----
    rst = 1'b1; we = 1'b1; ch = 2'd0; half = 8'd0; mode = 2'd2;
    tick();
    rst = 1'b0; we = 1'b0;
    check("rstwr_led", 32'(led_out), 32'd0);
    check("rstwr_wrap", 32'(wrap), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("rstwr_e%0d_led", k), 32'(led_out), 32'd0);
    end
    tick();
    check("rstwr_e4_led", 32'(led_out), 32'hF);
    check("rstwr_e4_wrap", 32'(wrap), 32'hF);

    // ---- NCH=3: write to cfg_ch=3 must be ignored ----
    tick();
    check("n3_reset_led", 32'(led_out_b), 32'd0);
    rst_b = 1'b0; we_b = 1'b1; ch_b = 2'd3; half_b = 4'd0; mode_b = 2'd0;
    for (int k = 0; k < 8; k++) begin
      tick();
      we_b = 1'b0;
      check($sformatf("n3_e%0d_led", k + 1), 32'(led_out_b), 32'(exp3_led[k]));
      check($sformatf("n3_e%0d_wrap", k + 1), 32'(wrap_b), 32'(exp3_wrap[k]));
    end

    // ---- Max half-period (2^CNT_W-1 = 15) in pulse mode on NCH=3 ch0 ----
    we_b = 1'b1; ch_b = 2'd0; half_b = 4'd15; mode_b = 2'd2;
    tick();
    we_b = 1'b0;
    check("maxhalf_write_led0", 32'(led_out_b[0]), 32'd0);
    lat = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      tick();
      if (led_out_b[0]) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check("maxhalf_first_pulse", 32'(lat), 32'd16);
    check("maxhalf_wrap0", 32'(wrap_b[0]), 32'd1);
    tick();
    check("maxhalf_pulse_one_cycle", 32'(led_out_b[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/led_blink_bank.md
Name: led_blink_bank

Overview:
- Parametrised bank of NCH independent LED blink generators. It generalises the fixed single-channel half-period toggle counters into one runtime-configurable block.
- Each channel has a programmable half-period and a mode: off, square-wave toggle, one-cycle pulse, or registered pass-through of an external input such as KEY.
- Sits in the sys_clk domain of the FPGA top level and drives LED[] directly.
- Configured by a simple one-cycle write strobe from top-level logic or a future Wishbone register block.

Parameters:
- NCH, 4, number of channels; legal range 2..16.
- CNT_W, 32, width of each half-period counter and of cfg_half.
- DEFAULT_HALF, 50000000, reset value of every channel's half-period register; must fit in CNT_W bits.
- DEFAULT_MODE, 2'd1, reset mode of every channel (1 = toggle).

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_rst  input  1  synchronous active-high reset.
- cfg_we  input  1  configuration write strobe, one-cycle pulse.
- cfg_ch  input  $clog2(NCH)  channel index for the write.
- cfg_half  input  CNT_W  new half-period value.
- cfg_mode  input  2  new mode: 0 off, 1 toggle, 2 pulse, 3 pass.
- led_in  input  NCH  per-channel pass-through source.
- led_out  output  NCH  per-channel LED drive, registered.
- wrap_pulse  output  NCH  one-cycle strobe when a channel's counter wraps, registered.

Behaviour:
- One clock: sys_clk. Reset: sys_rst, synchronous and active-high. No asynchronous reset anywhere.
- Per channel c the block holds:
  - cnt[c], CNT_W bits.
  - half[c], CNT_W bits.
  - mode[c], 2 bits.
  - led_out[c] and wrap_pulse[c].
- Reset values:
  - cnt = 0, half = DEFAULT_HALF, mode = DEFAULT_MODE.
  - led_out = 0, wrap_pulse = 0, all channels.
- Modes (the "state machine" is per channel, selected by mode[c]):
  - OFF (0): cnt held at 0; led_out = 0; wrap_pulse = 0.
  - TOGGLE (1):
    - If cnt == half: cnt <= 0, led_out <= ~led_out, wrap_pulse <= 1.
    - Otherwise: cnt <= cnt + 1, wrap_pulse <= 0.
    - Full period = 2*(half+1) cycles.
    - half = 0 toggles led_out every cycle with wrap_pulse held high.
  - PULSE (2):
    - Same counter as TOGGLE.
    - led_out <= 1 only in the cycle wrap_pulse <= 1; otherwise 0.
    - Gives a one-cycle high every half+1 cycles.
  - PASS (3): led_out <= led_in[c], one cycle latency; cnt held at 0; wrap_pulse = 0.
- Counter arithmetic:
  - Unsigned.
  - cnt never exceeds half, so it never wraps on overflow.
  - half = 2^CNT_W-1 is legal and wraps through the equality branch.
- Configuration write (cfg_we = 1 and cfg_ch < NCH) to channel c, at the next edge:
  - half[c] <= cfg_half, mode[c] <= cfg_mode.
  - cnt[c] <= 0, led_out[c] <= 0, wrap_pulse[c] <= 0.
  - A write overrides the counter update in the same cycle, including a would-be wrap.
  - The new mode and half take effect from the following cycle.
  - Writing to a channel resets its phase even when the values written are unchanged.
- Writes with cfg_ch >= NCH (possible when NCH is not a power of two) are ignored; no channel changes.
- Other channels are never affected by a write to channel c.
- Reset mid-operation: sys_rst wins over cfg_we and over counting; all state returns to reset values on that edge.
- Channels are fully independent; there is no cross-channel phase alignment.

Optional Feature:
- Macro: LED_BLINK_SYNC_EN.
- Defined:
  - led_in passes through a 2-flop synchronizer per bit before PASS mode uses it.
  - PASS latency becomes 3 cycles from a led_in change to led_out.
  - Synchronizer flops reset to 0.
- Undefined:
  - led_in is sampled directly; PASS latency is 1 cycle.
  - led_in must then already be synchronous to sys_clk.

Test Plan:
- Reset, NCH=4, DEFAULT_HALF=3, DEFAULT_MODE=1 -> led_out=4'b0000 during reset; after release all channels toggle every 4 cycles (period 8); wrap_pulse high 1 cycle every 4.
- Write ch1 half=0 mode=1 -> from 2 cycles after the write, led_out[1] toggles every cycle and wrap_pulse[1] stays 1; other channels keep their phase.
- Write ch2 mode=2 half=5 -> led_out[2] high exactly 1 cycle in every 6, coincident with wrap_pulse[2].
- Write ch3 mode=3, then drive led_in[3] 0->1 -> led_out[3] rises 1 cycle later (3 cycles with LED_BLINK_SYNC_EN).
- Write ch0 mode=0 while led_out[0]=1 -> led_out[0]=0 next edge and stays 0; wrap_pulse[0]=0. Then assert sys_rst with cfg_we=1 in the same cycle -> reset values, and the write is lost.
- NCH=3, write cfg_ch=3 -> no channel's half, mode, cnt or led_out changes.
